// File: rtl/bram_snapshot_ctrl.sv
// Snapshot capture controller: records 2**ADDR_WIDTH valid samples into an external BRAM after a trigger, then serves random-access readout.
// Optional trigger timestamp (trig_time) when BRAM_SNAPSHOT_TSTAMP_EN is defined.
module bram_snapshot_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  trig,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
`ifdef BRAM_SNAPSHOT_TSTAMP_EN
  output logic [31:0]           trig_time,
`endif
  output logic                  bram_wr,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // count value at which the next accepted sample is the final one
  localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH:0]     count_reg, count_next;
  logic                    bram_wr_reg, bram_wr_next;
  logic [ADDR_WIDTH-1:0]   bram_addr_reg, bram_addr_next;
  logic [DATA_WIDTH-1:0]   bram_din_reg, bram_din_next;
  logic                    rd_pend_reg, rd_pend_next;
  logic                    rd_valid_reg;
  logic                    trig_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      bram_wr_reg   <= 1'b0;
      bram_addr_reg <= '0;
      bram_din_reg  <= '0;
      rd_pend_reg   <= 1'b0;
      rd_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      bram_wr_reg   <= bram_wr_next;
      bram_addr_reg <= bram_addr_next;
      bram_din_reg  <= bram_din_next;
      rd_pend_reg   <= rd_pend_next;
      // the read pipeline completes regardless of later state changes
      rd_valid_reg  <= rd_pend_reg;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    bram_wr_next   = 1'b0;
    bram_addr_next = bram_addr_reg;
    bram_din_next  = bram_din_reg;
    rd_pend_next   = 1'b0;
    trig_accept    = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (arm) begin
          state_next = ARMED;
          count_next = '0;
        end else if (rd_en) begin
          bram_addr_next = rd_addr;
          rd_pend_next   = 1'b1;
        end
      end
      ARMED: begin
        if (arm) begin
          count_next = '0;
        end else if (trig && din_valid) begin
          bram_wr_next   = 1'b1;
          bram_addr_next = '0;
          bram_din_next  = din;
          count_next     = {{ADDR_WIDTH{1'b0}}, 1'b1};
          state_next     = CAPTURE;
          trig_accept    = 1'b1;
        end
      end
      CAPTURE: begin
        if (arm) begin
          state_next = ARMED;
          count_next = '0;
        end else if (din_valid) begin
          bram_wr_next   = 1'b1;
          bram_addr_next = count_reg[ADDR_WIDTH-1:0];
          bram_din_next  = din;
          count_next     = count_reg + 1'b1;
          if (count_reg == LAST_IDX) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef BRAM_SNAPSHOT_TSTAMP_EN
  logic [31:0] cyc_reg;
  logic [31:0] trig_time_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_reg       <= '0;
      trig_time_reg <= '0;
    end else begin
      cyc_reg <= cyc_reg + 32'd1;
      if (trig_accept) trig_time_reg <= cyc_reg;
    end
  end

  assign trig_time = trig_time_reg;
`else
  logic unused_trig_accept;
  assign unused_trig_accept = trig_accept;
`endif

  assign busy      = (state_reg == ARMED) || (state_reg == CAPTURE);
  assign done      = (state_reg == DONE);
  assign count     = count_reg;
  assign rd_data   = bram_dout;
  assign rd_valid  = rd_valid_reg;
  assign bram_wr   = bram_wr_reg;
  assign bram_addr = bram_addr_reg;
  assign bram_din  = bram_din_reg;

endmodule
